inpkt_word_router: RTL and testbench
====================================

// Module: inpkt_word_router
// PURPOSE
// - Sits directly downstream of the input packet header parser. Consumes its byte stream plus
//   pkt_data/pkt_end/pkt_type/pkt_id/pkt_err qualifiers.
// - Packs data bytes into WORD_WIDTH-bit words and tags each word with type, id, last and byte count.
// - Buffers words in a 2-entry output queue for the per-type application consumers.
// - Header and checksum bytes are never forwarded.
// PARAMETERS
// - WORD_WIDTH    16  output word width; multiple of 8, range 8..64
// - PKT_TYPE_MSB   2  MSB of the pkt_type field; matches the header parser setting
// PORTS
// - CLK        in   1             single clock, rising edge
// - RESET_N    in   1             asynchronous, active-low reset
// - din        in   8             byte, shared with the header parser input
// - wr_en      in   1             din valid, shared with the header parser input
// - pkt_data   in   1             header parser: current byte is packet data
// - pkt_end    in   1             header parser: current byte is last data byte
// - pkt_type   in   PKT_TYPE_MSB+1  header parser packet type, stable during data
// - pkt_id     in   16            header parser packet id, stable during data
// - pkt_err    in   1             header parser error state, sticky
// - full       out  1             upstream must not assert wr_en while high
// - dout       out  WORD_WIDTH    head word
// - dout_type  out  PKT_TYPE_MSB+1  type tag of head word
// - dout_id    out  16            id tag of head word
// - dout_last  out  1             head word is the last word of its packet
// - dout_bytes out  `MSB(WORD_WIDTH/8)+1  valid bytes in head word, 1..WORD_WIDTH/8
// - empty      out  1             no word available
// - rd_en      in   1             pop head word; ignored when empty
// - err        out  1             sticky: pkt_err seen, or a byte written while full
// BEHAVIOUR
// Reset (RESET_N=0, async)
// - Queue count=0, byte index=0, assembly register=0.
// - full=0, empty=1, err=0, dout/dout_type/dout_id/dout_last/dout_bytes=0.
// Byte acceptance
// - A byte is accepted when wr_en & pkt_data & ~full & ~err.
// - wr_en with pkt_data=0 (header/checksum bytes) is ignored.
// Packing
// - Little-endian: byte at index k goes to bits [8k+7:8k].
// - Index counts 0..WORD_WIDTH/8-1, then wraps to 0.
// Commit
// - Occurs in the same cycle as an accepted byte when index==WORD_WIDTH/8-1 or pkt_end=1.
// - The word is formed from the assembly register plus din, with unfilled upper bytes forced to 0.
// - The word is written to the queue tail with pkt_type, pkt_id, last=pkt_end and bytes=index+1.
// - Index resets to 0 and the assembly register clears.
// - Latency: committed word is visible on dout, with empty=0, on the next clock if the queue was empty.
// Queue
// - 2 entries; full = (count==2), registered, with no combinational path from rd_en.
// - Commit and rd_en in the same cycle: count is unchanged and ordering is preserved.
// - rd_en when empty: no effect.
// - dout* hold the head entry's value; after the last pop they retain the last popped values.
// Boundaries
// - Back-to-back packets: the first byte of the next packet always starts at index 0.
// - Packet of 1 byte: single word, last=1, bytes=1.
// - wr_en & pkt_data while full: byte dropped, err<=1.
// Error handling
// - pkt_err=1: partial assembly discarded (index=0, no commit), err<=1.
// - Further bytes are ignored until reset.
// - Words already queued remain readable.
// STRUCTURE
// - Shared include pkt_comm.vh: `MSB macro and packet type codes. No new typedefs.
// - One sub-module: pkt_word_fifo2, a 2-entry tagged FIFO with {word,type,id,last,bytes}
//   per entry and registered full/empty.
// - Top level: index counter, assembly register, commit and error logic.
// TESTING (WORD_WIDTH=16)
// - Data 11 22 33 44 (pkt_end on 44), rd_en=1 -> 0x2211 last=0 bytes=2; 0x4433 last=1 bytes=2.
// - Data 11 22 33 (pkt_end on 33) -> 0x2211; then 0x0033 last=1 bytes=1.
// - 1-byte packet AA, then packet BB CC with type=2, id=0x1234 -> 0x00AA last bytes=1;
//   0xCCBB type=2 id=0x1234 last.
// - rd_en=0, 6 data bytes -> full rises the cycle after byte 4. After one rd_en pulse,
//   full falls next cycle and bytes 5-6 commit as 0x6655.
// - pkt_err=1 after byte 11 of a word -> no word for 11, err=1, later bytes ignored,
//   earlier queued words still pop.
// - RESET_N low mid-word, then new packet 77 88 -> empty=1 during reset;
//   after release, 0x8877 appears (index restarted).

Source files
------------

// File: rtl/inpkt_word_router_pkg.sv
// ---------------------------------------------------------------------------
// inpkt_word_router_pkg
// Shared constants and sizing helpers for the input-packet word router and
// its tagged output queue.
//   PKT_ID_W    width of the packet id carried from the header parser
//   BYTE_W      width of one stream byte
//   pkt_msb(x)  index of the most significant set bit of x (x >= 1); the
//               byte-count tag is pkt_msb(bytes_per_word)+1 bits wide so it
//               can hold the full count 1..bytes_per_word
//   pkt_idx_w(n) width of a byte index counting 0..n-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package inpkt_word_router_pkg;

  localparam int PKT_ID_W = 16;
  localparam int BYTE_W   = 8;

  function automatic int pkt_msb(input int x);
    return $clog2(x + 1) - 1;
  endfunction

  function automatic int pkt_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_word_fifo2.sv
// ---------------------------------------------------------------------------
// pkt_word_fifo2
// Two-entry tagged FIFO. Each entry carries {word, type, id, last, bytes}.
// Entry 0 is always the head, so the head outputs come straight from a
// register. After the final pop the head register is left untouched, which
// keeps the last popped values visible on the outputs.
//
// Ports
//   CLK, RESET_N     clock, asynchronous active-low reset
//   push             write push_* into the tail (ignored while full)
//   push_word/type/id/last/bytes   entry to write
//   pop              drop the head entry (ignored while empty)
//   full, empty      registered occupancy flags (no path from push/pop)
//   head_word/type/id/last/bytes   current head entry
//
// Handshake: a push is taken on a rising edge when push=1 and full=0; a pop
// is taken when pop=1 and empty=0. Both may happen in the same cycle, in
// which case the occupancy is unchanged and order is preserved.
// ---------------------------------------------------------------------------
module pkt_word_fifo2
  import inpkt_word_router_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int TYPE_W     = 3,
  parameter int BYTES_W    = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_word,
  input  logic [TYPE_W-1:0]     push_type,
  input  logic [PKT_ID_W-1:0]   push_id,
  input  logic                  push_last,
  input  logic [BYTES_W-1:0]    push_bytes,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [WORD_WIDTH-1:0] head_word,
  output logic [TYPE_W-1:0]     head_type,
  output logic [PKT_ID_W-1:0]   head_id,
  output logic                  head_last,
  output logic [BYTES_W-1:0]    head_bytes
);

  localparam int ENT_W = WORD_WIDTH + TYPE_W + PKT_ID_W + 1 + BYTES_W;

  logic [ENT_W-1:0] ent0_q, ent1_q;
  logic [ENT_W-1:0] ent0_d, ent1_d;
  logic [ENT_W-1:0] push_ent;
  logic [1:0]       count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign push_ent = {push_word, push_type, push_id, push_last, push_bytes};
  assign do_push  = push & ~full_q;
  assign do_pop   = pop & ~empty_q;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = push_ent;
        else                 ent1_d = push_ent;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // With one entry left the head register keeps its value so the
        // outputs retain the word that was just popped.
        if (count_q == 2'd2) ent0_d = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Both gates open means 0 < count < 2, i.e. exactly one entry.
        ent0_d = push_ent;
      end
      default: begin
        ent0_d = ent0_q;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
      full_q  <= (count_d == 2'd2);
      empty_q <= (count_d == 2'd0);
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign {head_word, head_type, head_id, head_last, head_bytes} = ent0_q;

endmodule

// File: rtl/inpkt_word_router.sv
// ---------------------------------------------------------------------------
// inpkt_word_router
// Packs the data bytes of the header parser's stream into WORD_WIDTH-bit
// little-endian words, tags each with type/id/last/byte-count, and queues
// them in a two-entry FIFO for the per-type consumers. Header and checksum
// bytes (pkt_data=0) are never forwarded.
//
// Ports
//   CLK, RESET_N     clock, asynchronous active-low reset
//   din, wr_en       byte stream shared with the header parser
//   pkt_data         current byte is packet data
//   pkt_end          current byte is the last data byte of the packet
//   pkt_type, pkt_id packet qualifiers, stable while data flows
//   pkt_err          parser error state (sticky upstream)
//   full             upstream must not assert wr_en while high
//   dout, dout_type, dout_id, dout_last, dout_bytes   head word and tags
//   empty            no word available
//   rd_en            pop head word (ignored when empty)
//   err              sticky: parser error seen or data byte offered while full
//
// Handshake: a data byte is taken on a rising edge when
// wr_en & pkt_data & ~full & ~err & ~pkt_err. A word is read by holding
// rd_en high for one edge while empty=0.
// ---------------------------------------------------------------------------
module inpkt_word_router
  import inpkt_word_router_pkg::*;
#(
  parameter int WORD_WIDTH   = 16,
  parameter int PKT_TYPE_MSB = 2
) (
  input  logic                                 CLK,
  input  logic                                 RESET_N,
  input  logic [BYTE_W-1:0]                    din,
  input  logic                                 wr_en,
  input  logic                                 pkt_data,
  input  logic                                 pkt_end,
  input  logic [PKT_TYPE_MSB:0]                pkt_type,
  input  logic [PKT_ID_W-1:0]                  pkt_id,
  input  logic                                 pkt_err,
  output logic                                 full,
  output logic [WORD_WIDTH-1:0]                dout,
  output logic [PKT_TYPE_MSB:0]                dout_type,
  output logic [PKT_ID_W-1:0]                  dout_id,
  output logic                                 dout_last,
  output logic [pkt_msb(WORD_WIDTH/8):0]       dout_bytes,
  output logic                                 empty,
  input  logic                                 rd_en,
  output logic                                 err
);

  localparam int NB = WORD_WIDTH / BYTE_W;
  localparam int IW = pkt_idx_w(NB);
  localparam int BW = pkt_msb(NB) + 1;
  localparam int TW = PKT_TYPE_MSB + 1;

  logic [IW-1:0]         idx_q;
  logic [WORD_WIDTH-1:0] asm_q;
  logic                  err_q;

  logic                  accept;
  logic                  at_last;
  logic                  commit;
  logic [WORD_WIDTH-1:0] merged_word;
  logic [BW-1:0]         commit_bytes;

  // Parser error in the same cycle wins over the byte: nothing is accepted.
  assign accept  = wr_en & pkt_data & ~full & ~err_q & ~pkt_err;
  assign at_last = (idx_q == IW'(NB - 1));
  assign commit  = accept & (at_last | pkt_end);

  // Bytes above idx_q in asm_q are always zero (cleared on each commit), so
  // OR-ing the new byte in also leaves any unfilled upper bytes at zero.
  assign merged_word  = asm_q | (WORD_WIDTH'(din) << {idx_q, 3'b000});
  assign commit_bytes = BW'(idx_q) + BW'(1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q <= '0;
      asm_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (pkt_err | err_q) begin
        idx_q <= '0;
        asm_q <= '0;
      end else if (commit) begin
        idx_q <= '0;
        asm_q <= '0;
      end else if (accept) begin
        idx_q <= idx_q + IW'(1);
        asm_q <= merged_word;
      end
      if (pkt_err | (wr_en & pkt_data & full)) err_q <= 1'b1;
    end
  end

  pkt_word_fifo2 #(
    .WORD_WIDTH (WORD_WIDTH),
    .TYPE_W     (TW),
    .BYTES_W    (BW)
  ) u_fifo (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .push       (commit),
    .push_word  (merged_word),
    .push_type  (pkt_type),
    .push_id    (pkt_id),
    .push_last  (pkt_end),
    .push_bytes (commit_bytes),
    .pop        (rd_en),
    .full       (full),
    .empty      (empty),
    .head_word  (dout),
    .head_type  (dout_type),
    .head_id    (dout_id),
    .head_last  (dout_last),
    .head_bytes (dout_bytes)
  );

  assign err = err_q;

endmodule

// File: tb/tb_inpkt_word_router.sv
// ---------------------------------------------------------------------------
// tb_inpkt_word_router
// Bench for inpkt_word_router at WORD_WIDTH=16. The reference model keeps the
// current packet's bytes in a queue and the expected output words in exp_q;
// a word is formed whenever the byte queue reaches two bytes or pkt_end.
// Inputs change on the falling edge; outputs are compared on the falling
// edge, half a cycle after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_inpkt_word_router;

  localparam int W  = 16;
  localparam int NB = 2;
  localparam int TW = 3;
  localparam int BW = 2;
  localparam int EW = W + TW + 16 + 1 + BW;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [7:0]    din;
  logic          wr_en, pkt_data, pkt_end, pkt_err, rd_en;
  logic [TW-1:0] pkt_type;
  logic [15:0]   pkt_id;
  logic          full, empty, err, dout_last;
  logic [W-1:0]  dout;
  logic [TW-1:0] dout_type;
  logic [15:0]   dout_id;
  logic [BW-1:0] dout_bytes;

  always #5 CLK = ~CLK;

  inpkt_word_router #(.WORD_WIDTH(W), .PKT_TYPE_MSB(TW-1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .din(din), .wr_en(wr_en),
    .pkt_data(pkt_data), .pkt_end(pkt_end), .pkt_type(pkt_type),
    .pkt_id(pkt_id), .pkt_err(pkt_err), .full(full), .dout(dout),
    .dout_type(dout_type), .dout_id(dout_id), .dout_last(dout_last),
    .dout_bytes(dout_bytes), .empty(empty), .rd_en(rd_en), .err(err)
  );

  logic [EW-1:0] exp_q[$];
  logic [7:0]    cur_q[$];
  bit            m_err;
  bit            in_pkt;
  int            n_vec = 0;
  int            n_miss = 0;

  wire [EW-1:0] head_obs = {dout, dout_type, dout_id, dout_last, dout_bytes};

  function automatic logic [EW-1:0] mk(input logic [W-1:0] w, input logic [TW-1:0] t,
                                       input logic [15:0] id, input logic l, input int b);
    return {w, t, id, l, BW'(b)};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    exp_q.delete();
    cur_q.delete();
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit           was_full;
    logic [W-1:0] w;
    logic [W-1:0] b;
    if (!RESET_N) begin
      model_reset();
    end else begin
      was_full = (exp_q.size() == 2);
      if (rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (!m_err) begin
        if (pkt_err) begin
          cur_q.delete();
          m_err = 1'b1;
        end else if (wr_en && pkt_data) begin
          if (was_full) begin
            m_err = 1'b1;
          end else begin
            cur_q.push_back(din);
            if (cur_q.size() == NB || pkt_end) begin
              w = '0;
              foreach (cur_q[k]) begin
                b = W'(cur_q[k]);
                w = w | (b << (8 * k));
              end
              exp_q.push_back(mk(w, pkt_type, pkt_id, pkt_end, cur_q.size()));
              cur_q.delete();
            end
          end
        end
      end
    end
  endtask

  // ---------------- clock / drivers ----------------
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic drive(input logic [7:0] d, input logic data, input logic pend, input logic rd);
    din = d; wr_en = 1'b1; pkt_data = data; pkt_end = pend; rd_en = rd;
  endtask

  task automatic idle(input logic rd);
    wr_en = 1'b0; pkt_data = 1'b0; pkt_end = 1'b0; rd_en = rd;
  endtask

  task automatic do_reset();
    idle(1'b0);
    pkt_err = 1'b0;
    RESET_N = 1'b0;
    model_reset();
    cycle();
    cycle();
    RESET_N = 1'b1;
    cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    din = 8'h00; pkt_type = '0; pkt_id = '0;
    idle(1'b0);
    pkt_err = 1'b0;
    RESET_N = 1'b0;
    model_reset();
    cycle();
    cycle();
    n_vec++;
    if ({full, empty, err} !== 3'b010) begin
      n_miss++; $display("FAIL reset_flags: observed %b, expected 010", {full, empty, err});
    end
    n_vec++;
    if (head_obs !== '0) begin
      n_miss++; $display("FAIL reset_head: observed %h, expected 0", head_obs);
    end
    RESET_N = 1'b1;
    cycle();
  endtask

  task automatic test_four_bytes();
    pkt_type = 3'd1; pkt_id = 16'h0101;
    drive(8'h11, 1, 0, 0); cycle();
    drive(8'h22, 1, 0, 0); cycle();
    n_vec++;
    if (empty !== 1'b0 || head_obs !== mk(16'h2211, 3'd1, 16'h0101, 0, 2)) begin
      n_miss++; $display("FAIL four_w0: observed %h empty %b, expected %h", head_obs, empty,
                         mk(16'h2211, 3'd1, 16'h0101, 0, 2));
    end
    drive(8'h33, 1, 0, 1); cycle();
    drive(8'h44, 1, 1, 1); cycle();
    n_vec++;
    if (empty !== 1'b0 || head_obs !== mk(16'h4433, 3'd1, 16'h0101, 1, 2)) begin
      n_miss++; $display("FAIL four_w1: observed %h empty %b, expected %h", head_obs, empty,
                         mk(16'h4433, 3'd1, 16'h0101, 1, 2));
    end
    idle(1'b1); cycle();
    n_vec++;
    if (empty !== 1'b1 || head_obs !== mk(16'h4433, 3'd1, 16'h0101, 1, 2)) begin
      n_miss++; $display("FAIL four_retain: observed %h empty %b, expected last popped word",
                         head_obs, empty);
    end
    idle(1'b0);
  endtask

  task automatic test_three_bytes();
    pkt_type = 3'd0; pkt_id = 16'h0005;
    drive(8'h11, 1, 0, 0); cycle();
    drive(8'h22, 1, 0, 0); cycle();
    drive(8'h33, 1, 1, 0); cycle();
    n_vec++;
    if (full !== 1'b1 || head_obs !== mk(16'h2211, 3'd0, 16'h0005, 0, 2)) begin
      n_miss++; $display("FAIL three_w0: observed %h full %b, expected %h full 1", head_obs, full,
                         mk(16'h2211, 3'd0, 16'h0005, 0, 2));
    end
    idle(1'b1); cycle();
    n_vec++;
    if (full !== 1'b0 || head_obs !== mk(16'h0033, 3'd0, 16'h0005, 1, 1)) begin
      n_miss++; $display("FAIL three_w1: observed %h full %b, expected %h full 0", head_obs, full,
                         mk(16'h0033, 3'd0, 16'h0005, 1, 1));
    end
    cycle();
    n_vec++;
    if (empty !== 1'b1) begin
      n_miss++; $display("FAIL three_drain: observed empty %b, expected 1", empty);
    end
    idle(1'b0);
  endtask

  task automatic test_back_to_back();
    pkt_type = 3'd1; pkt_id = 16'h0007;
    drive(8'hAA, 1, 1, 0); cycle();
    n_vec++;
    if (head_obs !== mk(16'h00AA, 3'd1, 16'h0007, 1, 1)) begin
      n_miss++; $display("FAIL b2b_single: observed %h, expected %h", head_obs,
                         mk(16'h00AA, 3'd1, 16'h0007, 1, 1));
    end
    pkt_type = 3'd2; pkt_id = 16'h1234;
    drive(8'hBB, 1, 0, 0); cycle();
    drive(8'hCC, 1, 1, 0); cycle();
    idle(1'b1); cycle();
    n_vec++;
    if (head_obs !== mk(16'hCCBB, 3'd2, 16'h1234, 1, 2)) begin
      n_miss++; $display("FAIL b2b_second: observed %h, expected %h", head_obs,
                         mk(16'hCCBB, 3'd2, 16'h1234, 1, 2));
    end
    cycle();
    idle(1'b0);
  endtask

  task automatic test_full_flow();
    pkt_type = 3'd3; pkt_id = 16'h00F0;
    drive(8'h11, 1, 0, 0); cycle();
    drive(8'h22, 1, 0, 0); cycle();
    drive(8'h33, 1, 0, 0); cycle();
    n_vec++;
    if (full !== 1'b0) begin
      n_miss++; $display("FAIL full_early: observed %b, expected 0", full);
    end
    drive(8'h44, 1, 0, 0); cycle();
    n_vec++;
    if (full !== 1'b1) begin
      n_miss++; $display("FAIL full_rise: observed %b, expected 1", full);
    end
    idle(1'b0); cycle();
    idle(1'b1); cycle();
    n_vec++;
    if (full !== 1'b0 || head_obs !== mk(16'h4433, 3'd3, 16'h00F0, 0, 2)) begin
      n_miss++; $display("FAIL full_fall: observed %h full %b, expected %h full 0", head_obs, full,
                         mk(16'h4433, 3'd3, 16'h00F0, 0, 2));
    end
    drive(8'h55, 1, 0, 0); cycle();
    drive(8'h66, 1, 1, 0); cycle();
    n_vec++;
    if (full !== 1'b1 || err !== 1'b0) begin
      n_miss++; $display("FAIL full_refill: observed full %b err %b, expected 1 0", full, err);
    end
    idle(1'b1); cycle();
    n_vec++;
    if (head_obs !== mk(16'h6655, 3'd3, 16'h00F0, 1, 2)) begin
      n_miss++; $display("FAIL full_w6655: observed %h, expected %h", head_obs,
                         mk(16'h6655, 3'd3, 16'h00F0, 1, 2));
    end
    cycle();
    idle(1'b0);
  endtask

  task automatic test_overflow();
    pkt_type = 3'd0; pkt_id = 16'hBEEF;
    drive(8'h01, 1, 0, 0); cycle();
    drive(8'h02, 1, 0, 0); cycle();
    drive(8'h03, 1, 0, 0); cycle();
    drive(8'h04, 1, 1, 0); cycle();
    drive(8'h05, 1, 0, 0); cycle();
    n_vec++;
    if (err !== 1'b1 || head_obs !== mk(16'h0201, 3'd0, 16'hBEEF, 0, 2)) begin
      n_miss++; $display("FAIL ovf_err: observed %h err %b, expected %h err 1", head_obs, err,
                         mk(16'h0201, 3'd0, 16'hBEEF, 0, 2));
    end
    idle(1'b1); cycle();
    n_vec++;
    if (head_obs !== mk(16'h0403, 3'd0, 16'hBEEF, 1, 2)) begin
      n_miss++; $display("FAIL ovf_keep: observed %h, expected %h", head_obs,
                         mk(16'h0403, 3'd0, 16'hBEEF, 1, 2));
    end
    cycle();
    drive(8'h09, 1, 1, 0); cycle();
    idle(1'b0); cycle();
    n_vec++;
    if (empty !== 1'b1 || err !== 1'b1) begin
      n_miss++; $display("FAIL ovf_ignore: observed empty %b err %b, expected 1 1", empty, err);
    end
    do_reset();
  endtask

  task automatic test_pkt_err();
    pkt_type = 3'd4; pkt_id = 16'h0A0A;
    drive(8'h01, 1, 0, 0); cycle();
    drive(8'h02, 1, 1, 0); cycle();
    drive(8'h11, 1, 0, 0); cycle();
    idle(1'b0); pkt_err = 1'b1; cycle();
    n_vec++;
    if (err !== 1'b1) begin
      n_miss++; $display("FAIL perr_flag: observed %b, expected 1", err);
    end
    drive(8'h22, 1, 0, 0); cycle();
    pkt_err = 1'b0;
    drive(8'h33, 1, 1, 0); cycle();
    idle(1'b0); cycle();
    n_vec++;
    if (full !== 1'b0 || empty !== 1'b0 || head_obs !== mk(16'h0201, 3'd4, 16'h0A0A, 1, 2)) begin
      n_miss++; $display("FAIL perr_queued: observed %h full %b empty %b, expected %h 0 0",
                         head_obs, full, empty, mk(16'h0201, 3'd4, 16'h0A0A, 1, 2));
    end
    idle(1'b1); cycle();
    n_vec++;
    if (empty !== 1'b1) begin
      n_miss++; $display("FAIL perr_drain: observed empty %b, expected 1", empty);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_word();
    pkt_type = 3'd5; pkt_id = 16'h7777;
    drive(8'h01, 1, 0, 0); cycle();
    drive(8'h02, 1, 1, 0); cycle();
    drive(8'h55, 1, 0, 0); cycle();
    idle(1'b0);
    RESET_N = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (empty !== 1'b1 || full !== 1'b0 || head_obs !== '0) begin
      n_miss++; $display("FAIL rst_async: observed %h empty %b full %b, expected 0 1 0",
                         head_obs, empty, full);
    end
    cycle();
    RESET_N = 1'b1;
    drive(8'h77, 1, 0, 0); cycle();
    drive(8'h88, 1, 1, 0); cycle();
    n_vec++;
    if (head_obs !== mk(16'h8877, 3'd5, 16'h7777, 1, 2)) begin
      n_miss++; $display("FAIL rst_restart: observed %h, expected %h", head_obs,
                         mk(16'h8877, 3'd5, 16'h7777, 1, 2));
    end
    idle(1'b1); cycle();
    idle(1'b0);
  endtask

  task automatic test_random();
    bit rd, wr, data, pend;
    in_pkt = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rd = ($urandom_range(0, 1) == 1);
      wr = (exp_q.size() < 2) && ($urandom_range(0, 3) != 0);
      data = ($urandom_range(0, 4) != 0);
      pend = data && ($urandom_range(0, 3) == 0);
      if (wr && data && !in_pkt) begin
        pkt_type = TW'($urandom_range(0, 7));
        pkt_id = 16'($urandom);
      end
      if (wr) begin
        drive(8'($urandom), data, pend, rd);
        if (data) in_pkt = !pend;
      end else begin
        idle(rd);
      end
      if (rd && exp_q.size() > 0) begin
        n_vec++;
        if (head_obs !== exp_q[0]) begin
          n_miss++; $display("FAIL rand_head[%0d]: observed %h, expected %h", i, head_obs, exp_q[0]);
        end
      end
      cycle();
      n_vec++;
      if ({full, empty, err} !== {exp_q.size() == 2, exp_q.size() == 0, m_err}) begin
        n_miss++; $display("FAIL rand_flags[%0d]: observed %b, expected %b", i, {full, empty, err},
                           {exp_q.size() == 2, exp_q.size() == 0, m_err});
      end
    end
    // finish any open packet, then drain
    if (in_pkt) begin
      drive(8'hEE, 1, 1, 0); cycle();
      while (exp_q.size() == 2) begin idle(1'b1); cycle(); end
      drive(8'hEE, 1, 1, 0); cycle();
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      if (exp_q.size() > 0) begin
        n_vec++;
        if (head_obs !== exp_q[0]) begin
          n_miss++; $display("FAIL rand_drain[%0d]: observed %h, expected %h", i, head_obs, exp_q[0]);
        end
      end
      cycle();
    end
    n_vec++;
    if (empty !== 1'b1) begin
      n_miss++; $display("FAIL rand_empty: observed %b, expected 1", empty);
    end
    idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_four_bytes();
    test_three_bytes();
    test_back_to_back();
    test_full_flow();
    test_overflow();
    test_pkt_err();
    test_reset_mid_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
